// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared types and constants for the multicycle RV32I core.
//   state_t    - control FSM states
//   OPC_*      - RV32I major opcodes handled by the core
//   alu_op_t   - ALU operation select
//   imm_type_t - immediate format select
//   alu_op_from() - maps funct3/funct7[5] to an ALU operation
package riscv_mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;

    // funct7[5] means SUB only for register-register ops; for OP-IMM it is
    // part of the ADDI immediate. For shifts it selects arithmetic right.
    function automatic alu_op_t alu_op_from(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_reg);
        case (f3)
            3'd0:    return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile_ff.sv
// regfile_ff: flop-based register file, one write port, two async read ports.
//   clk, reset_n        - clock, async active-low reset (clears all entries)
//   we, waddr, wdata    - write port; writes to entry 0 are discarded
//   raddr_a/b, rdata_a/b - combinational read ports; entry 0 always reads 0
module regfile_ff #(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [$clog2(N)-1:0] raddr_a,
    output logic [W-1:0]         rdata_a,
    input  logic [$clog2(N)-1:0] raddr_b,
    output logic [W-1:0]         rdata_b
);

    logic [W-1:0] regs [N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core: non-pipelined RV32I core (no FENCE/ECALL/EBREAK/CSR).
// FSM: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH; TRAP is terminal.
// Memory handshake: mem_req is valid-like and stays high with mem_we,
// mem_addr, mem_wdata and mem_be frozen until a cycle with mem_ready=1; that
// cycle completes the transfer and read data is taken from mem_rdata then.
// Ports:
//   clk, reset_n                    - clock, async active-low reset
//   mem_req/we/addr/wdata/be        - memory request (registered)
//   mem_rdata, mem_ready            - memory response
//   halted, retire, pc_out          - status (registered)
//   dbg_state                       - current FSM state
//   cycle_cnt, instret_cnt          - perf counters, only with RISCV_MC_PERF_EN
module riscv_multicycle_core
    import riscv_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 12,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic        retire,
    output logic [31:0] pc_out,
    output state_t      dbg_state
`ifdef RISCV_MC_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
`endif
);

    localparam logic [31:0] ADDR_MASK =
        (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_WIDTH) - 32'd1);

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    state_t      state;
    logic [31:0] pc, ir, a, b, imm, res, next_pc;
    alu_op_t     alu_op;

    // Instruction fields; IR stays valid from DECODE through WB.
    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic is_load, is_store, is_branch, is_jal, is_jalr;
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);

    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        rf_we;
    assign rf_we = (state == S_WB) && !(is_branch || is_store);

    regfile_ff #(.N(32), .W(32)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (res),
        .raddr_a (rs1),
        .rdata_a (rf_rdata_a),
        .raddr_b (rs2),
        .rdata_b (rf_rdata_b)
    );

    // Decode: immediate format, ALU op, legality.
    imm_type_t   imm_type;
    logic [31:0] imm_c;
    logic        dec_valid;
    alu_op_t     dec_alu_op;

    always_comb begin
        imm_type = IMM_I;
        if (opcode == OPC_LUI || opcode == OPC_AUIPC) imm_type = IMM_U;
        else if (is_jal)                              imm_type = IMM_J;
        else if (is_branch)                           imm_type = IMM_B;
        else if (is_store)                            imm_type = IMM_S;
        case (imm_type)
            IMM_S:   imm_c = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm_c = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm_c = {ir[31:12], 12'b0};
            IMM_J:   imm_c = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_c = {{20{ir[31]}}, ir[31:20]};
        endcase
        dec_alu_op = ALU_ADD;
        if (opcode == OPC_OP || opcode == OPC_OPIMM)
            dec_alu_op = alu_op_from(f3, ir[30], opcode == OPC_OP);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: dec_valid = 1'b1;
            OPC_JALR:   dec_valid = (f3 == 3'd0);
            OPC_BRANCH: dec_valid = (f3 != 3'd2) && (f3 != 3'd3);
            OPC_LOAD:   dec_valid = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            OPC_STORE:  dec_valid = (f3 <= 3'd2);
            OPC_OPIMM:  dec_valid = (f3 == 3'd1) ? (f7 == 7'h00) :
                                    (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            OPC_OP:     dec_valid = (f7 == 7'h00) ||
                                    (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            default:    dec_valid = 1'b0;
        endcase
    end

    // Execute: ALU, branch condition, targets, store lane formatting.
    logic [31:0] op_a, op_b, alu_y, br_target, jump_target, seq_pc;
    logic [31:0] exec_next_pc, exec_res, st_wdata;
    logic [3:0]  st_be;
    logic        br_cond, taken, misaligned, exec_trap;

    always_comb begin
        op_a = a;
        if (opcode == OPC_AUIPC)    op_a = pc;
        else if (opcode == OPC_LUI) op_a = '0;
        op_b = (opcode == OPC_OP) ? b : imm;
        case (alu_op)
            ALU_SUB:  alu_y = op_a - op_b;
            ALU_SLL:  alu_y = op_a << op_b[4:0];
            ALU_SLT:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_y = {31'b0, op_a < op_b};
            ALU_XOR:  alu_y = op_a ^ op_b;
            ALU_SRL:  alu_y = op_a >> op_b[4:0];
            ALU_SRA:  alu_y = 32'($signed(op_a) >>> op_b[4:0]);
            ALU_OR:   alu_y = op_a | op_b;
            ALU_AND:  alu_y = op_a & op_b;
            default:  alu_y = op_a + op_b;
        endcase
        case (f3)
            3'd0:    br_cond = (a == b);
            3'd1:    br_cond = (a != b);
            3'd4:    br_cond = $signed(a) < $signed(b);
            3'd5:    br_cond = $signed(a) >= $signed(b);
            3'd6:    br_cond = a < b;
            default: br_cond = a >= b;
        endcase
        seq_pc       = pc + 32'd4;
        br_target    = pc + imm;
        jump_target  = is_jalr ? (alu_y & ~32'd1) : br_target;
        taken        = is_jal || is_jalr || (is_branch && br_cond);
        exec_next_pc = taken ? jump_target : seq_pc;
        exec_res     = (is_jal || is_jalr) ? seq_pc : alu_y;
        // f3[1:0]: 00 byte, 01 half, 10 word (same for loads and stores)
        misaligned   = ((f3[1:0] == 2'b01) && alu_y[0]) ||
                       ((f3[1:0] == 2'b10) && (alu_y[1:0] != 2'b00));
        exec_trap    = (taken && (jump_target[1:0] != 2'b00)) ||
                       ((is_load || is_store) && misaligned);
        case (f3[1:0])
            2'b00: begin
                st_wdata = {4{b[7:0]}};
                st_be    = 4'b0001 << alu_y[1:0];
            end
            2'b01: begin
                st_wdata = {2{b[15:0]}};
                st_be    = alu_y[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = b;
                st_be    = 4'hF;
            end
        endcase
    end

    // Load alignment: bring the addressed byte/half down to bit 0, then extend.
    logic [31:0] ld_word, ld_data;
    always_comb begin
        ld_word = mem_rdata >> {mem_addr[1:0], 3'b000};
        case (f3)
            3'd0:    ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            3'd1:    ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            3'd4:    ld_data = {24'b0, ld_word[7:0]};
            3'd5:    ld_data = {16'b0, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            imm       <= '0;
            alu_op    <= ALU_ADD;
            res       <= '0;
            next_pc   <= RESET_PC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            halted    <= 1'b0;
            retire    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // Only the first fetch after reset arrives here idle;
                    // later fetches are already launched by WB.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'hF;
                        mem_addr <= pc & ADDR_MASK;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!dec_valid) begin
                        halted <= 1'b1;
                        state  <= S_TRAP;
                    end else begin
                        a      <= rf_rdata_a;
                        b      <= rf_rdata_b;
                        imm    <= imm_c;
                        alu_op <= dec_alu_op;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_trap) begin
                        halted <= 1'b1;
                        state  <= S_TRAP;
                    end else begin
                        res     <= exec_res;
                        next_pc <= exec_next_pc;
                        if (is_load || is_store) begin
                            mem_req  <= 1'b1;
                            mem_we   <= is_store;
                            mem_addr <= alu_y & ADDR_MASK;
                            mem_be   <= is_store ? st_be : 4'hF;
                            if (is_store) mem_wdata <= st_wdata;
                            state    <= S_MEM;
                        end else begin
                            retire <= 1'b1;
                            state  <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_load) res <= ld_data;
                        retire  <= 1'b1;
                        state   <= S_WB;
                    end
                end
                S_WB: begin
                    // Launch the next fetch directly so it costs no idle cycle.
                    pc       <= next_pc;
                    retire   <= 1'b0;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_be   <= 4'hF;
                    mem_addr <= next_pc & ADDR_MASK;
                    state    <= S_FETCH;
                end
                default: ; // S_TRAP: frozen until reset
            endcase
        end
    end

    assign pc_out    = pc;
    assign dbg_state = state;

`ifdef RISCV_MC_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (!halted) cycle_cnt   <= cycle_cnt + 1'b1;
            if (retire)  instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed testbench for riscv_multicycle_core with a behavioural memory.
module tb_riscv_multicycle_core;
    import riscv_mc_pkg::*;

    logic        clk, reset_n;
    logic        mem_req, mem_we, mem_ready, halted, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [3:0]  mem_be;
    state_t      dbg_state;
`ifdef RISCV_MC_PERF_EN
    logic [3:0]  cycle_cnt, instret_cnt;
`endif

    riscv_multicycle_core #(.RESET_PC(32'h0), .ADDR_WIDTH(12), .CNT_WIDTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .retire    (retire),
        .pc_out    (pc_out),
        .dbg_state (dbg_state)
`ifdef RISCV_MC_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int          retire_cyc[8];
    int          n_retire, first_req, exp_cyc, data_reqs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rf(input int i);
        return dut.u_rf.regs[i];
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:1023];
    int          fetch_waits = 0, data_waits = 0, wait_cnt = 0, cur_waits;
    bit          manual_resp = 0, data_seen = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!manual_resp) begin
                if (mem_req) begin
                    if (dbg_state == S_MEM && !data_seen) begin
                        data_reqs++;
                        data_seen = 1;
                    end
                    cur_waits = (dbg_state == S_MEM) ? data_waits : fetch_waits;
                    if (wait_cnt >= cur_waits) begin
                        mem_ready = 1'b1;
                        wait_cnt  = 0;
                        if (mem_we) begin
                            for (int k = 0; k < 4; k++)
                                if (mem_be[k]) mem[mem_addr[11:2]][8*k +: 8] = mem_wdata[8*k +: 8];
                        end else begin
                            mem_rdata = mem[mem_addr[11:2]];
                        end
                    end else begin
                        mem_ready = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt  = 0;
                    data_seen = 0;
                end
            end
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], OPC_STORE};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], OPC_BRANCH};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPC_OP};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OPC_JAL};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs until halted or the cycle budget expires; cycle 1 is the first
    // cycle with mem_req high. Retiring PCs are matched against exp_q.
    task automatic run_prog(input int max_cyc, input bit with_reset);
        int cyc;
        bit prev_h;
        cyc = 0; first_req = -1; n_retire = 0; exp_cyc = 0; data_reqs = 0; prev_h = 0;
        if (with_reset) do_reset();
        while (!halted && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (!prev_h) exp_cyc++;
            prev_h = halted;
            if (first_req < 0 && mem_req) first_req = cyc;
            if (retire) begin
                if (n_retire < 8) retire_cyc[n_retire] = cyc - first_req + 1;
                n_retire++;
                if (exp_q.size() > 0) check("retire_pc", pc_out, exp_q.pop_front());
            end
        end
        check("halted", {31'b0, halted}, 32'd1);
        check("sb_drain", exp_q.size(), 32'd0);
    endtask

    // ---------------- tests ----------------
    initial begin
        reset_n = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_retire", {31'b0, retire}, 32'd0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_ir", dut.ir, 32'd0);

        // ADDI x1,x0,5 ; ADDI x2,x1,-7 ; illegal
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OPC_OPIMM);
        mem[1] = enc_i(-7, 1, 0, 2, OPC_OPIMM);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        run_prog(200, 1);
        check("addi_x1", rf(1), 32'd5);
        check("addi_x2", rf(2), 32'hFFFF_FFFE);
        check("addi_ret0_cyc", retire_cyc[0], 32'd4);
        check("addi_ret1_cyc", retire_cyc[1], 32'd8);
        check("addi_nret", n_retire, 32'd2);

        // Loads with 3 data wait states, byte store, word reload
        clear_mem();
        data_waits = 3;
        mem[64] = 32'h8000_00F0;
        mem[0] = enc_i(32'h100, 0, 0, 3, OPC_LOAD);   // LB  x3
        mem[1] = enc_i(32'h100, 0, 4, 4, OPC_LOAD);   // LBU x4
        mem[2] = enc_i(32'h102, 0, 5, 5, OPC_LOAD);   // LHU x5
        mem[3] = enc_i(32'h102, 0, 1, 6, OPC_LOAD);   // LH  x6
        mem[4] = enc_s(32'h105, 4, 0, 0);             // SB  x4 -> 0x105
        mem[5] = enc_i(32'h104, 0, 2, 8, OPC_LOAD);   // LW  x8
        run_prog(400, 1);
        check("lb_x3", rf(3), 32'hFFFF_FFF0);
        check("lbu_x4", rf(4), 32'h0000_00F0);
        check("lhu_x5", rf(5), 32'h0000_8000);
        check("lh_x6", rf(6), 32'hFFFF_8000);
        check("sb_mem", mem[65], 32'h0000_F000);
        check("lw_x8", rf(8), 32'h0000_F000);
        check("load_wait_cyc", retire_cyc[0], 32'd8);
        data_waits = 0;

        // Signed vs unsigned branch
        clear_mem();
        mem[0] = enc_i(-1, 0, 0, 1, OPC_OPIMM);
        mem[1] = enc_i(1, 0, 0, 2, OPC_OPIMM);
        mem[2] = enc_b(8, 2, 1, 4);                   // BLT  -> 16
        mem[3] = enc_i(1, 0, 0, 9, OPC_OPIMM);        // skipped
        mem[4] = enc_b(8, 2, 1, 6);                   // BLTU not taken
        mem[5] = enc_i(7, 0, 0, 10, OPC_OPIMM);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd20);
        run_prog(300, 1);
        check("blt_skip_x9", rf(9), 32'd0);
        check("bltu_fall_x10", rf(10), 32'd7);

        // Shifts, SLT, SUB, JAL, JALR
        clear_mem();
        mem[0] = enc_u(32'h80000, 13, OPC_LUI);
        mem[1] = enc_i(32'h404, 13, 5, 14, OPC_OPIMM); // SRAI x14,x13,4
        mem[2] = enc_i(4, 13, 5, 15, OPC_OPIMM);       // SRLI x15,x13,4
        mem[3] = enc_j(8, 16);                         // JAL x16,+8
        mem[4] = enc_i(1, 0, 0, 17, OPC_OPIMM);        // skipped
        mem[5] = enc_r(0, 0, 13, 2, 18);               // SLT x18,x13,x0
        mem[6] = enc_r(32'h20, 13, 15, 0, 19);         // SUB x19,x15,x13
        mem[7] = enc_i(36, 0, 0, 20, OPC_JALR);        // JALR x20,36(x0)
        mem[8] = enc_i(1, 0, 0, 21, OPC_OPIMM);        // skipped
        run_prog(400, 1);
        check("srai_x14", rf(14), 32'hF800_0000);
        check("srli_x15", rf(15), 32'h0800_0000);
        check("jal_link_x16", rf(16), 32'd16);
        check("jal_skip_x17", rf(17), 32'd0);
        check("slt_x18", rf(18), 32'd1);
        check("sub_x19", rf(19), 32'h8800_0000);
        check("jalr_link_x20", rf(20), 32'd32);
        check("jalr_skip_x21", rf(21), 32'd0);

        // Misaligned LW traps before any data request
        clear_mem();
        mem[0] = enc_i(3, 0, 0, 1, OPC_OPIMM);
        mem[1] = enc_i(32'h102, 0, 2, 2, OPC_LOAD);
        mem[2] = enc_i(9, 0, 0, 2, OPC_OPIMM);
        run_prog(200, 1);
        check("trap_x1", rf(1), 32'd3);
        check("trap_x2", rf(2), 32'd0);
        check("trap_data_reqs", data_reqs, 32'd0);
        check("trap_nret", n_retire, 32'd1);
        repeat (5) @(negedge clk);
        check("trap_mem_req", {31'b0, mem_req}, 32'd0);
        check("trap_retire", {31'b0, retire}, 32'd0);
        check("trap_pc_hold", pc_out, 32'd4);
        reset_n = 1'b0;
        @(negedge clk);
        check("trap_rst_pc", pc_out, 32'd0);
        check("trap_rst_halted", {31'b0, halted}, 32'd0);

        // Reset during a fetch wait, with mem_ready pulsed inside reset
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OPC_OPIMM);
        fetch_waits = 6;
        do_reset();
        repeat (3) @(negedge clk);
        check("midfetch_req", {31'b0, mem_req}, 32'd1);
        manual_resp = 1;
        #1;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("midfetch_ir_rst", dut.ir, 32'd0);
        reset_n = 1'b1;
        wait_cnt = 0;
        fetch_waits = 0;
        manual_resp = 0;
        @(negedge clk);
        check("refetch_req", {31'b0, mem_req}, 32'd1);
        check("refetch_addr", mem_addr, 32'h0);
        check("refetch_ir", dut.ir, 32'd0);
        run_prog(200, 0);
        check("refetch_x1", rf(1), 32'd5);

`ifdef RISCV_MC_PERF_EN
        // 16 ADDIs with 4-bit counters: 67 counted cycles -> 67 mod 16 = 3
        clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = enc_i(1, 1, 0, 1, OPC_OPIMM);
        run_prog(400, 1);
        check("perf_x1", rf(1), 32'd16);
        check("perf_instret", {28'b0, instret_cnt}, 32'd0);
        check("perf_cycle", {28'b0, cycle_cnt}, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
